spi_slave_word: RTL and testbench
=================================

// Module: spi_slave_word
// PURPOSE
//  Parametrised SPI slave front end for the LED controller host link: word width and SPI mode are configurable.
//  Deserialises MOSI MSB-first into DATA_WIDTH-bit words and flags frame start/end and partial words.
//  Counts words per CS frame. Optional MISO transmit path.
//  Sits between the board SPI pins and the command/pixel parser, fully in the clk_in domain.
// PARAMETERS
//  DATA_WIDTH   8   bits per word, 4..32
//  SPI_MODE     0   {CPOL,CPHA}, 0..3
//  SYNC_STAGES  2   synchroniser flops on sclk/mosi/cs_n, 2..3
//  CNT_WIDTH    16  width of per-frame word counter
// PORTS
//  clk_in           in   1           system clock; must be >= 6x sclk frequency
//  rst_n_in         in   1           asynchronous active-low reset
//  spi_sclk_in      in   1           SPI clock, async to clk_in
//  spi_mosi_in      in   1           SPI data in, async
//  spi_cs_n_in      in   1           SPI chip select, active low, async
//  frame_start_out  out  1           1-cycle pulse: synced CS asserted
//  frame_end_out    out  1           1-cycle pulse: synced CS deasserted
//  partial_out      out  1           valid with frame_end_out: frame ended mid-word
//  word_rdy_out     out  1           1-cycle pulse: word_data_out is new
//  word_data_out    out  DATA_WIDTH  last complete word; held until next word
//  word_cnt_out     out  CNT_WIDTH   words completed in current frame
//  tx_load_out      out  1           (SPI_SLAVE_MISO_EN) tx_data_in sampled this cycle
//  tx_data_in       in   DATA_WIDTH  (SPI_SLAVE_MISO_EN) next word to shift out
//  spi_miso_out     out  1           (SPI_SLAVE_MISO_EN) SPI data out
// BEHAVIOUR
//  - Reset: every output is 0. All counters, shift registers and synchronisers are cleared.
//  - Inputs pass through SYNC_STAGES flops. Edges are detected from the synced sclk against its previous value.
//  - Sample edge: rising for modes 0 and 3, falling for modes 1 and 2. The shift edge is the opposite edge.
//  - Frame state machine IDLE -> ACTIVE on synced cs_n falling. frame_start_out pulses that cycle. bit_cnt=0, word_cnt=0.
//  - ACTIVE -> IDLE on synced cs_n rising. frame_end_out pulses that cycle.
//    partial_out = (bit_cnt!=0). Partial bits are discarded and bit_cnt is cleared.
//    word_cnt_out holds its value until the next frame_start.
//  - In ACTIVE, on a sample edge: shift in the synced mosi and set bit_cnt+=1.
//    When bit_cnt==DATA_WIDTH-1, bit_cnt wraps to 0 and word_data_out is updated.
//    word_rdy_out pulses in the cycle after the edge is detected (latency 1 clk from detection).
//    word_cnt_out increments in the same cycle and saturates at all-ones.
//  - In IDLE, sclk edges are ignored.
//  - When CS deasserts in the same cycle as a sample edge, CS wins: the edge is ignored.
//  - Async reset mid-frame aborts with no word_rdy and no frame_end. The first frame_start after reset needs a fresh CS falling edge.
// CONFIGURATION
//  `SPI_SLAVE_MISO_EN defined:
//  - tx_load_out pulses on frame_start and with each word_rdy_out; tx_data_in is loaded into the tx shift register that cycle.
//  - MSB is driven first.
//  - CPHA=0: the MSB is on spi_miso_out from the cycle after load. Shift on each shift edge.
//  - CPHA=1: shift on each shift edge; the first shift edge presents the MSB.
//  - spi_miso_out=0 in IDLE. Tristating is done at top level.
//  `SPI_SLAVE_MISO_EN undefined: tx_load_out, tx_data_in and spi_miso_out are absent, and no tx logic is generated.
// STRUCTURE
//  - Package spi_pkg: typedef enum logic [1:0] spi_mode_t {SPI_MODE0..SPI_MODE3}.
//  - spi_pkg also holds typedef enum {SPI_IDLE, SPI_ACTIVE} spi_frame_state_t.
//  - spi_pkg also holds functions sample_on_rise(spi_mode_t) and cpha(spi_mode_t).
//  - Sub-module spi_sync_edge:
//    - parameter STAGES, signals clk_in, rst_n_in, data_in;
//    - outputs data_out, pos_edge_out, neg_edge_out;
//    - one instance each for sclk and cs_n; mosi uses a plain synchroniser.
// TESTING (clk_in = 50 MHz, sclk = 5 MHz)
//  1. Mode 0, W=8: CS low, byte 0xA5, CS high.
//     -> frame_start; one word_rdy with data 0xA5, word_cnt 1; frame_end with partial 0.
//  2. Mode 3, W=16: words 0x1234 then 0xBEEF in one frame.
//     -> two word_rdy pulses, data in that order, word_cnt 2.
//  3. Mode 0: 5 bits (10110) then CS high.
//     -> no word_rdy; frame_end=1 with partial=1; next frame byte 0x3C gives 0x3C.
//  4. Mode 0: rst_n_in low after 4 bits, release, then full frame 0x81.
//     -> outputs 0 during reset; only 0x81 is reported, word_cnt 1.
//  5. MISO_EN, mode 1, W=8: tx_data_in=0x5A, master sends 0xFF.
//     -> master samples 0x5A; tx_load pulses at frame_start and after word_rdy.
//  6. Back-to-back frames with a 2-cycle CS-high gap, 3 words each.
//     -> word_cnt 3 each frame; frame_end and frame_start both seen.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and mode helpers for the SPI slave word front end.
package spi_pkg;

    typedef enum logic [1:0] {
        SPI_MODE0,
        SPI_MODE1,
        SPI_MODE2,
        SPI_MODE3
    } spi_mode_t;

    typedef enum logic {
        SPI_IDLE,
        SPI_ACTIVE
    } spi_frame_state_t;

    // Mode encodes {CPOL,CPHA}; modes 0 and 3 sample on the rising sclk edge.
    function automatic logic sample_on_rise(spi_mode_t mode);
        return (mode == SPI_MODE0) || (mode == SPI_MODE3);
    endfunction

    function automatic logic cpha(spi_mode_t mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_slave_word_if.sv
// SPI pin and word-output bundle for spi_slave_word.
// The tx signals exist only when SPI_SLAVE_MISO_EN is defined.
interface spi_slave_word_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  spi_sclk_in;
    logic                  spi_mosi_in;
    logic                  spi_cs_n_in;
    logic                  frame_start_out;
    logic                  frame_end_out;
    logic                  partial_out;
    logic                  word_rdy_out;
    logic [DATA_WIDTH-1:0] word_data_out;
    logic [CNT_WIDTH-1:0]  word_cnt_out;
`ifdef SPI_SLAVE_MISO_EN
    logic                  tx_load_out;
    logic [DATA_WIDTH-1:0] tx_data_in;
    logic                  spi_miso_out;

    modport slave (
        input  spi_sclk_in, spi_mosi_in, spi_cs_n_in, tx_data_in,
        output frame_start_out, frame_end_out, partial_out, word_rdy_out,
        output word_data_out, word_cnt_out, tx_load_out, spi_miso_out
    );
    modport master (
        output spi_sclk_in, spi_mosi_in, spi_cs_n_in, tx_data_in,
        input  frame_start_out, frame_end_out, partial_out, word_rdy_out,
        input  word_data_out, word_cnt_out, tx_load_out, spi_miso_out
    );
`else
    modport slave (
        input  spi_sclk_in, spi_mosi_in, spi_cs_n_in,
        output frame_start_out, frame_end_out, partial_out, word_rdy_out,
        output word_data_out, word_cnt_out
    );
    modport master (
        output spi_sclk_in, spi_mosi_in, spi_cs_n_in,
        input  frame_start_out, frame_end_out, partial_out, word_rdy_out,
        input  word_data_out, word_cnt_out
    );
`endif
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with edge detection on the synchronised level.
module spi_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic data_in,
    output logic data_out,
    output logic pos_edge_out,
    output logic neg_edge_out
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], data_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign data_out     = sync_q[STAGES-1];
    assign pos_edge_out = data_out & ~prev_q;
    assign neg_edge_out = ~data_out & prev_q;

endmodule

// File: rtl/spi_slave_word.sv
// SPI slave front end: syncs pins into clk_in, frames on CS and assembles MSB-first words.
// Define SPI_SLAVE_MISO_EN to build the MISO transmit path.
module spi_slave_word
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SPI_MODE    = 0,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input logic             clk_in,
    input logic             rst_n_in,
    spi_slave_word_if.slave bus
);
    localparam spi_mode_t        MODE        = spi_mode_t'(SPI_MODE[1:0]);
    localparam bit               SAMPLE_RISE = sample_on_rise(MODE);
    localparam int unsigned      BIT_W       = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(DATA_WIDTH - 1);

    logic                   sclk_s, sclk_pos, sclk_neg;
    logic                   cs_s, cs_pos, cs_neg;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;
    logic                   unused_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .data_in      (bus.spi_sclk_in),
        .data_out     (sclk_s),
        .pos_edge_out (sclk_pos),
        .neg_edge_out (sclk_neg)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .data_in      (bus.spi_cs_n_in),
        .data_out     (cs_s),
        .pos_edge_out (cs_pos),
        .neg_edge_out (cs_neg)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi_in};
        end
    end

    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign unused_sync = sclk_s ^ cs_s;

    spi_frame_state_t state_q, state_d;
    logic             frame_start, frame_end, active, do_sample;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= SPI_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        unique case (state_q)
            SPI_IDLE: begin
                if (cs_neg) begin
                    state_d     = SPI_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            SPI_ACTIVE: begin
                if (cs_pos) begin
                    state_d   = SPI_IDLE;
                    frame_end = 1'b1;
                end
            end
        endcase
    end

    assign active = (state_q == SPI_ACTIVE);
    // CS release outranks a coincident sample edge.
    assign do_sample = active & (SAMPLE_RISE ? sclk_pos : sclk_neg) & ~cs_pos;

    logic [DATA_WIDTH-1:0] shift_q, shift_d, word_data_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [CNT_WIDTH-1:0]  word_cnt_q;
    logic                  word_rdy_q;

    assign shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shift_q     <= '0;
            word_data_q <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            word_rdy_q  <= 1'b0;
        end else begin
            word_rdy_q <= 1'b0;
            if (frame_start) begin
                bit_cnt_q  <= '0;
                word_cnt_q <= '0;
            end else if (frame_end) begin
                bit_cnt_q <= '0;
            end else if (do_sample) begin
                shift_q <= shift_d;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_q   <= '0;
                    word_data_q <= shift_d;
                    word_rdy_q  <= 1'b1;
                    if (word_cnt_q != '1) begin
                        word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                end
            end
        end
    end

    assign bus.frame_start_out = frame_start;
    assign bus.frame_end_out   = frame_end;
    assign bus.partial_out     = frame_end & (bit_cnt_q != '0);
    assign bus.word_rdy_out    = word_rdy_q;
    assign bus.word_data_out   = word_data_q;
    assign bus.word_cnt_out    = word_cnt_q;

`ifdef SPI_SLAVE_MISO_EN
    localparam bit CPHA = cpha(MODE);

    logic [DATA_WIDTH-1:0] tx_shift_q;
    logic                  tx_out_q, tx_load, do_shift;

    assign tx_load  = frame_start | word_rdy_q;
    assign do_shift = active & (SAMPLE_RISE ? sclk_neg : sclk_pos) & ~cs_pos;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_shift_q <= '0;
            tx_out_q   <= 1'b0;
        end else if (tx_load) begin
            tx_shift_q <= bus.tx_data_in;
        end else if (!active) begin
            tx_out_q <= 1'b0;
        end else if (do_shift) begin
            if (CPHA) begin
                tx_out_q   <= tx_shift_q[DATA_WIDTH-1];
                tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end else if (bit_cnt_q != '0) begin
                // With CPHA=0 the shift edge after a word's last sample would eat the fresh MSB.
                tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    assign bus.tx_load_out  = tx_load;
    assign bus.spi_miso_out = active & (CPHA ? tx_out_q : tx_shift_q[DATA_WIDTH-1]);
`endif

endmodule

// File: tb/tb_spi_slave_word.sv
// Directed bench for spi_slave_word: mode 0/W8, mode 3/W16 and mode 1/W8 instances.
module tb_spi_slave_word;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic sclk_r [3];
    logic mosi_r [3];
    logic cs_r   [3];
    logic miso2;

    spi_slave_word_if #(.DATA_WIDTH(8),  .CNT_WIDTH(3))  bus0 ();
    spi_slave_word_if #(.DATA_WIDTH(16), .CNT_WIDTH(16)) bus1 ();
    spi_slave_word_if #(.DATA_WIDTH(8),  .CNT_WIDTH(16)) bus2 ();

    assign bus0.spi_sclk_in = sclk_r[0];
    assign bus0.spi_mosi_in = mosi_r[0];
    assign bus0.spi_cs_n_in = cs_r[0];
    assign bus1.spi_sclk_in = sclk_r[1];
    assign bus1.spi_mosi_in = mosi_r[1];
    assign bus1.spi_cs_n_in = cs_r[1];
    assign bus2.spi_sclk_in = sclk_r[2];
    assign bus2.spi_mosi_in = mosi_r[2];
    assign bus2.spi_cs_n_in = cs_r[2];
`ifdef SPI_SLAVE_MISO_EN
    logic [7:0] tx0, tx1;
    assign bus0.tx_data_in = 8'h00;
    assign bus1.tx_data_in = 16'h0000;
    assign bus2.tx_data_in = tx1;
    assign miso2 = bus2.spi_miso_out;
`else
    assign miso2 = 1'b0;
`endif

    spi_slave_word #(.DATA_WIDTH(8), .SPI_MODE(0), .SYNC_STAGES(2), .CNT_WIDTH(3)) u_mode0 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus0.slave)
    );
    spi_slave_word #(.DATA_WIDTH(16), .SPI_MODE(3), .SYNC_STAGES(3), .CNT_WIDTH(16)) u_mode3 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus1.slave)
    );
    spi_slave_word #(.DATA_WIDTH(8), .SPI_MODE(1), .SYNC_STAGES(2), .CNT_WIDTH(16)) u_mode1 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus2.slave)
    );

    // Pulse monitors, sampled mid-cycle.
    int fs0 = 0, fe0 = 0, wr0 = 0, fs1 = 0, fe1 = 0, wr1 = 0, fs2 = 0, fe2 = 0, wr2 = 0;
    int txl2 = 0, txl_fs2 = 0, txl_wr2 = 0;
    logic part0 = 1'b0;
    logic [31:0] words0[$], words1[$], words2[$];
    int fecnt0[$];

    always @(negedge clk) begin
        if (bus0.frame_start_out) fs0 <= fs0 + 1;
        if (bus0.frame_end_out) begin
            fe0   <= fe0 + 1;
            part0 <= bus0.partial_out;
            fecnt0.push_back(int'(bus0.word_cnt_out));
        end
        if (bus0.word_rdy_out) begin
            wr0 <= wr0 + 1;
            words0.push_back({24'h0, bus0.word_data_out});
        end
        if (bus1.frame_start_out) fs1 <= fs1 + 1;
        if (bus1.frame_end_out) fe1 <= fe1 + 1;
        if (bus1.word_rdy_out) begin
            wr1 <= wr1 + 1;
            words1.push_back({16'h0, bus1.word_data_out});
        end
        if (bus2.frame_start_out) fs2 <= fs2 + 1;
        if (bus2.frame_end_out) fe2 <= fe2 + 1;
        if (bus2.word_rdy_out) begin
            wr2 <= wr2 + 1;
            words2.push_back({24'h0, bus2.word_data_out});
        end
`ifdef SPI_SLAVE_MISO_EN
        if (bus2.tx_load_out) txl2 <= txl2 + 1;
        if (bus2.tx_load_out && bus2.frame_start_out) txl_fs2 <= txl_fs2 + 1;
        if (bus2.tx_load_out && bus2.word_rdy_out) txl_wr2 <= txl_wr2 + 1;
`endif
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic cs_low(input int d);
        cs_r[d] = 1'b0;
        #100;
    endtask

    task automatic cs_high(input int d);
        #100;
        cs_r[d] = 1'b1;
        #200;
    endtask

    // Master shifting nbits MSB-first; d=1 is CPOL=1, d>0 is CPHA=1. rx is the sampled MISO.
    task automatic spi_bits(input int d, input logic [31:0] data, input int nbits,
                            output logic [31:0] rx);
        logic cpol, ph;
        cpol = (d == 1);
        ph   = (d != 0);
        rx   = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!ph) begin
                mosi_r[d] = data[i];
                #100;
                rx = {rx[30:0], (d == 2) & miso2};
                sclk_r[d] = ~cpol;
                #100;
                sclk_r[d] = cpol;
            end else begin
                sclk_r[d] = ~cpol;
                mosi_r[d] = data[i];
                #100;
                rx = {rx[30:0], (d == 2) & miso2};
                sclk_r[d] = cpol;
                #100;
            end
        end
    endtask

    task automatic frame0(input logic [7:0] b);
        logic [31:0] rx;
        cs_low(0);
        spi_bits(0, {24'h0, b}, 8, rx);
        cs_high(0);
    endtask

    task automatic test_reset();
        settle(3);
        checks++;
        if ({bus0.frame_start_out, bus0.frame_end_out, bus0.partial_out, bus0.word_rdy_out,
             bus0.word_data_out, bus0.word_cnt_out} !== '0) begin
            errors++;
            $display("FAIL reset_mode0: outputs %0h, required 0", {bus0.frame_start_out,
                     bus0.frame_end_out, bus0.partial_out, bus0.word_rdy_out,
                     bus0.word_data_out, bus0.word_cnt_out});
        end
        checks++;
        if ({bus1.word_rdy_out, bus1.word_data_out, bus1.word_cnt_out} !== '0) begin
            errors++;
            $display("FAIL reset_mode3: outputs %0h, required 0",
                     {bus1.word_rdy_out, bus1.word_data_out, bus1.word_cnt_out});
        end
`ifdef SPI_SLAVE_MISO_EN
        checks++;
        if ({bus2.tx_load_out, bus2.spi_miso_out} !== 2'b00) begin
            errors++;
            $display("FAIL reset_tx: tx_load/miso %b, required 00",
                     {bus2.tx_load_out, bus2.spi_miso_out});
        end
`endif
        rst_n = 1'b1;
        settle(10);
        checks++;
        if (fs0 + fs1 + fs2 + fe0 + fe1 + fe2 !== 0) begin
            errors++;
            $display("FAIL reset_release_frames: %0d frame pulses, required 0",
                     fs0 + fs1 + fs2 + fe0 + fe1 + fe2);
        end
    endtask

    task automatic test_mode0_byte();
        int fs_b = fs0, fe_b = fe0, wr_b = wr0, wb = words0.size(), fb = fecnt0.size();
        frame0(8'hA5);
        settle(2);
        checks++;
        if (fs0 - fs_b !== 1) begin
            errors++;
            $display("FAIL m0_frame_start: got %0d pulses, required 1", fs0 - fs_b);
        end
        checks++;
        if (wr0 - wr_b !== 1) begin
            errors++;
            $display("FAIL m0_word_rdy: got %0d pulses, required 1", wr0 - wr_b);
        end
        checks++;
        if (words0[wb] !== 32'hA5) begin
            errors++;
            $display("FAIL m0_data: got %0h, required a5", words0[wb]);
        end
        checks++;
        if (fe0 - fe_b !== 1 || part0 !== 1'b0) begin
            errors++;
            $display("FAIL m0_frame_end: got %0d pulses partial %b, required 1 partial 0",
                     fe0 - fe_b, part0);
        end
        checks++;
        if (fecnt0[fb] !== 1 || bus0.word_cnt_out !== 3'd1) begin
            errors++;
            $display("FAIL m0_word_cnt: got %0d at end, %0d held, required 1 and 1",
                     fecnt0[fb], bus0.word_cnt_out);
        end
    endtask

    task automatic test_mode3_words();
        int fs_b = fs1, fe_b = fe1, wr_b = wr1, wb = words1.size();
        logic [31:0] rx;
        cs_low(1);
        spi_bits(1, 32'h1234, 16, rx);
        spi_bits(1, 32'hBEEF, 16, rx);
        cs_high(1);
        settle(2);
        checks++;
        if (wr1 - wr_b !== 2) begin
            errors++;
            $display("FAIL m3_word_rdy: got %0d pulses, required 2", wr1 - wr_b);
        end
        checks++;
        if (words1[wb] !== 32'h1234 || words1[wb+1] !== 32'hBEEF) begin
            errors++;
            $display("FAIL m3_data: got %0h %0h, required 1234 beef", words1[wb], words1[wb+1]);
        end
        checks++;
        if (bus1.word_cnt_out !== 16'd2 || fs1 - fs_b !== 1 || fe1 - fe_b !== 1) begin
            errors++;
            $display("FAIL m3_frame: cnt %0d fs %0d fe %0d, required 2 1 1",
                     bus1.word_cnt_out, fs1 - fs_b, fe1 - fe_b);
        end
    endtask

    task automatic test_partial();
        int fe_b = fe0, wr_b = wr0;
        logic [31:0] rx;
        cs_low(0);
        spi_bits(0, 32'b10110, 5, rx);
        cs_high(0);
        settle(2);
        checks++;
        if (wr0 - wr_b !== 0) begin
            errors++;
            $display("FAIL partial_no_word: got %0d word_rdy, required 0", wr0 - wr_b);
        end
        checks++;
        if (fe0 - fe_b !== 1 || part0 !== 1'b1) begin
            errors++;
            $display("FAIL partial_flag: got %0d frame_end partial %b, required 1 partial 1",
                     fe0 - fe_b, part0);
        end
        frame0(8'h3C);
        settle(2);
        checks++;
        if (bus0.word_data_out !== 8'h3C || part0 !== 1'b0 || bus0.word_cnt_out !== 3'd1) begin
            errors++;
            $display("FAIL partial_recover: data %0h partial %b cnt %0d, required 3c 0 1",
                     bus0.word_data_out, part0, bus0.word_cnt_out);
        end
    endtask

    task automatic test_reset_midframe();
        int fs_b, fe_b, wr_b, wb;
        logic [31:0] rx;
        cs_low(0);
        spi_bits(0, 32'b1010, 4, rx);
        rst_n = 1'b0;
        settle(2);
        checks++;
        if ({bus0.frame_end_out, bus0.word_rdy_out, bus0.word_data_out,
             bus0.word_cnt_out} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: data %0h cnt %0d, required 0 0",
                     bus0.word_data_out, bus0.word_cnt_out);
        end
        fs_b = fs0;
        fe_b = fe0;
        wr_b = wr0;
        wb   = words0.size();
        #100;
        rst_n = 1'b1;
        settle(10);
        cs_high(0);
        settle(2);
        checks++;
        if (fs0 - fs_b !== 0 || fe0 - fe_b !== 0) begin
            errors++;
            $display("FAIL rst_mid_no_frame: fs %0d fe %0d, required 0 0",
                     fs0 - fs_b, fe0 - fe_b);
        end
        frame0(8'h81);
        settle(2);
        checks++;
        if (wr0 - wr_b !== 1 || words0[wb] !== 32'h81 || bus0.word_cnt_out !== 3'd1) begin
            errors++;
            $display("FAIL rst_mid_next: %0d words first %0h cnt %0d, required 1 81 1",
                     wr0 - wr_b, words0[wb], bus0.word_cnt_out);
        end
    endtask

    task automatic test_cs_wins();
        int fe_b = fe0, wr_b = wr0;
        logic [31:0] rx;
        cs_low(0);
        spi_bits(0, 32'h7F, 7, rx);
        mosi_r[0] = 1'b1;
        #100;
        sclk_r[0] = 1'b1;
        cs_r[0]   = 1'b1;
        #200;
        sclk_r[0] = 1'b0;
        settle(4);
        checks++;
        if (wr0 - wr_b !== 0 || fe0 - fe_b !== 1 || part0 !== 1'b1) begin
            errors++;
            $display("FAIL cs_wins: word_rdy %0d frame_end %0d partial %b, required 0 1 1",
                     wr0 - wr_b, fe0 - fe_b, part0);
        end
    endtask

    task automatic test_mode1_miso();
        int fs_b = fs2, fe_b = fe2, wr_b = wr2, wb = words2.size();
        int tl_b = txl2, tlf_b = txl_fs2, tlw_b = txl_wr2;
        logic [31:0] rx;
        cs_low(2);
        spi_bits(2, 32'hFF, 8, rx);
        cs_high(2);
        settle(2);
        checks++;
        if (wr2 - wr_b !== 1 || words2[wb] !== 32'hFF || fs2 - fs_b !== 1 || fe2 - fe_b !== 1) begin
            errors++;
            $display("FAIL m1_rx: %0d words data %0h fs %0d fe %0d, required 1 ff 1 1",
                     wr2 - wr_b, words2[wb], fs2 - fs_b, fe2 - fe_b);
        end
`ifdef SPI_SLAVE_MISO_EN
        checks++;
        if (rx[7:0] !== 8'h5A) begin
            errors++;
            $display("FAIL m1_miso: master sampled %0h, required 5a", rx[7:0]);
        end
        checks++;
        if (txl2 - tl_b !== 2 || txl_fs2 - tlf_b !== 1 || txl_wr2 - tlw_b !== 1) begin
            errors++;
            $display("FAIL m1_tx_load: total %0d at_start %0d at_rdy %0d, required 2 1 1",
                     txl2 - tl_b, txl_fs2 - tlf_b, txl_wr2 - tlw_b);
        end
        checks++;
        if (bus2.spi_miso_out !== 1'b0) begin
            errors++;
            $display("FAIL m1_miso_idle: got %b, required 0", bus2.spi_miso_out);
        end
`else
        if (tl_b + tlf_b + tlw_b + int'(rx[0]) < 0) $display("unreachable");
`endif
    endtask

    task automatic test_saturate();
        int wr_b = wr0, fb = fecnt0.size();
        logic [31:0] rx;
        cs_low(0);
        for (int i = 1; i <= 9; i++) spi_bits(0, i, 8, rx);
        cs_high(0);
        settle(2);
        checks++;
        if (wr0 - wr_b !== 9 || bus0.word_data_out !== 8'h09) begin
            errors++;
            $display("FAIL sat_words: %0d words last %0h, required 9 09",
                     wr0 - wr_b, bus0.word_data_out);
        end
        checks++;
        if (bus0.word_cnt_out !== 3'd7 || fecnt0[fb] !== 7) begin
            errors++;
            $display("FAIL sat_cnt: held %0d at end %0d, required 7 7",
                     bus0.word_cnt_out, fecnt0[fb]);
        end
    endtask

    task automatic test_back_to_back();
        int fs_b = fs0, fe_b = fe0, wr_b = wr0, wb = words0.size(), fb = fecnt0.size();
        logic [31:0] rx;
        cs_low(0);
        spi_bits(0, 32'h11, 8, rx);
        spi_bits(0, 32'h22, 8, rx);
        spi_bits(0, 32'h33, 8, rx);
        #100;
        cs_r[0] = 1'b1;
        #40;
        cs_low(0);
        spi_bits(0, 32'h44, 8, rx);
        spi_bits(0, 32'h55, 8, rx);
        spi_bits(0, 32'h66, 8, rx);
        cs_high(0);
        settle(2);
        checks++;
        if (fs0 - fs_b !== 2 || fe0 - fe_b !== 2) begin
            errors++;
            $display("FAIL b2b_frames: fs %0d fe %0d, required 2 2", fs0 - fs_b, fe0 - fe_b);
        end
        checks++;
        if (fecnt0[fb] !== 3 || fecnt0[fb+1] !== 3) begin
            errors++;
            $display("FAIL b2b_cnt: got %0d %0d, required 3 3", fecnt0[fb], fecnt0[fb+1]);
        end
        checks++;
        if (wr0 - wr_b !== 6 || words0[wb+2] !== 32'h33 || words0[wb+3] !== 32'h44) begin
            errors++;
            $display("FAIL b2b_data: %0d words w2 %0h w3 %0h, required 6 33 44",
                     wr0 - wr_b, words0[wb+2], words0[wb+3]);
        end
    endtask

    initial begin
        sclk_r[0] = 1'b0;
        sclk_r[1] = 1'b1;
        sclk_r[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mosi_r[i] = 1'b0;
            cs_r[i]   = 1'b1;
        end
`ifdef SPI_SLAVE_MISO_EN
        tx1 = 8'h5A;
        tx0 = 8'h00;
`endif
        test_reset();
        test_mode0_byte();
        test_mode3_words();
        test_partial();
        test_reset_midframe();
        test_cs_wins();
        test_mode1_miso();
        test_saturate();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
